pmod_frame_rx: RTL and testbench
================================

Name: pmod_frame_rx

Overview:
- Host-side front end of the PMOD-to-AXI bridge.
- Oversamples the asynchronous PMOD link (pck, pwrite, pwd) on the AXI clock and deserializes the 2-bit beats of each frame into a command (len, addr, write data).
- Hands the command to the AXI master engine over a valid/ready channel.
- Serializes the returned read data back onto prd, with pwait as host flow control.

Parameters:
- LEN_BEATS, 5, header length-field beats (10-bit len, LSB-first, 2 bits/beat)
- ADDR_BEATS, 16, address beats (32-bit addr, LSB-first)
- MAX_BEATS, 32, maximum data beats per frame (64 bits)
- WPAD_BEATS, 12, discarded pad beats after write data
- TIMEOUT, 1024, M_AXI_ACLK cycles without a pck edge before a mid-frame abort

Ports:
- M_AXI_ACLK  in  1  sole clock
- M_AXI_ARESET  in  1  reset, synchronous, active-high
- pck  in  1  PMOD beat clock, asynchronous, ~54 ns period, idles low
- pwrite  in  1  frame type, 1=write; asynchronous
- pwd  in  2  host-to-device beat; changes just after pck rise
- prd  out  2  device-to-host read beat
- pwait  out  1  high = host must stall
- cmd_valid  out  1  command valid
- cmd_ready  in  1  AXI engine accepts the command
- cmd_write  out  1  command type
- cmd_len  out  6  data beats, 0..32
- cmd_addr  out  32  byte address
- cmd_wdata  out  64  write data; beat k at bits [2k+1:2k], upper bits zero
- rsp_valid  in  1  read data available
- rsp_ready  out  1  read data accepted
- rsp_data  in  64  read data, same packing as cmd_wdata
- frame_err  out  1  one-cycle pulse on abort or length clamp

Behaviour:
- Synchronization
  - pck, pwrite and pwd each pass through a 2-flop synchronizer; pck also gets a third flop for edge detection.
  - A beat is a synchronized pck falling edge; the synchronized pwd is captured at that edge (mid-beat).
  - pwrite is captured on beat 0.
- States: HDR_LEN, HDR_ADDR, WDATA, WPAD, ISSUE, RWAIT, RDATA.
  - HDR_LEN: LEN_BEATS beats, then HDR_ADDR.
  - HDR_ADDR: ADDR_BEATS beats, then:
    - WDATA if write and len>0;
    - ISSUE if read and len>0;
    - HDR_LEN if len==0 (no command issued).
  - WDATA: len beats, then WPAD.
  - WPAD: WPAD_BEATS beats, then ISSUE.
  - ISSUE: hold cmd_valid until cmd_ready. On accept:
    - write: go to HDR_LEN;
    - read: go to RWAIT.
  - RWAIT: rsp_ready=1; on rsp_valid, load the shifter from rsp_data and go to RDATA.
  - RDATA: prd shows the current beat; advance on each beat; after len beats go to HDR_LEN.
- len>MAX_BEATS: clamp to MAX_BEATS and pulse frame_err. Clamped write beats beyond MAX_BEATS are dropped while still being counted against the 10-bit len.
- cmd fields are registered and stay stable while cmd_valid=1 (AXI valid rule); cmd_valid is never withdrawn before cmd_ready.
- pwait is high in ISSUE (read or write) and in RWAIT. It falls the cycle after rsp capture, or after a write command is accepted.
  - Write beats arriving during ISSUE are a host protocol violation; they are ignored.
- prd = rsp beat 0 on the cycle after capture; otherwise prd=0 outside RDATA.
- Timeout: in any state other than HDR_LEN (beat count 0), ISSUE and RWAIT:
  - TIMEOUT cycles with no pck edge → HDR_LEN, counters cleared, frame_err pulse.
  - Only the timeout counter runs in ISSUE and RWAIT; a timeout there is suppressed.
- Reset (any state, mid-frame included):
  - state HDR_LEN; beat counters 0;
  - prd=0, pwait=0, cmd_valid=0, rsp_ready=0, frame_err=0;
  - cmd_* data fields 0; synchronizers cleared.
- Latency:
  - final beat edge to cmd_valid: 1 cycle;
  - rsp_valid&rsp_ready to pwait low: 1 cycle.

Decomposition:
- Package pmod_pkg holds:
  - the state enum;
  - the header field widths: LEN_W=10, ADDR_W=32, DATA_W=64, BEAT_W=2;
  - the cmd struct type.
- One sub-module, pmod_sync_edge: 2-flop synchronizer plus fall-edge pulse for pck, with pwd/pwrite synchronized on the same stages for alignment.

Test Plan:
- Read: len=4, addr=0x4000_0000, rsp_data=0xdeadbeef two cycles after cmd accept → cmd_write=0, cmd_len=4, cmd_addr=0x4000_0000; pwait high ISSUE→capture; prd beats 11,11,10,11.
- Write: len=4, addr=0x4060_0004, data 0x68, 12 pad beats → exactly one cmd with cmd_write=1, cmd_len=4, cmd_wdata=0x68; next frame header parsed correctly.
- Backpressure: cmd_ready low 20 cycles → cmd_valid and fields stable throughout, pwait high; single accept when ready rises.
- Timeout: pck stops after 7 header beats → after TIMEOUT cycles frame_err pulses once, state HDR_LEN; a following full read frame decodes correctly.
- len=40 read → frame_err pulse, cmd_len=32, 32 prd beats then HDR_LEN.
- Reset asserted during RDATA beat 2 → next cycle prd=0, pwait=0, rsp_ready=0; a fresh frame decodes normally.

Source files
------------

// File: rtl/pmod_pkg.sv
// Shared types and field widths for the PMOD frame receiver.
package pmod_pkg;

    localparam int LEN_W     = 10;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int BEAT_W    = 2;
    localparam int CMD_LEN_W = 6;

    typedef enum logic [2:0] {
        HDR_LEN,
        HDR_ADDR,
        WDATA,
        WPAD,
        ISSUE,
        RWAIT,
        RDATA
    } state_t;

    typedef struct packed {
        logic                 write;
        logic [CMD_LEN_W-1:0] len;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    wdata;
    } cmd_t;

    function automatic logic [CMD_LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                       input logic [LEN_W-1:0] limit);
        return (len > limit) ? limit[CMD_LEN_W-1:0] : len[CMD_LEN_W-1:0];
    endfunction

endpackage

// File: rtl/pmod_frame_rx_if.sv
// Command / read-response channel between the frame receiver and the AXI master engine.
interface pmod_frame_rx_if;
    import pmod_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [CMD_LEN_W-1:0] cmd_len;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [DATA_W-1:0]    cmd_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_len, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_len, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/pmod_sync_edge.sv
// Two-flop synchronizer for the PMOD inputs plus pck edge detection on a third stage.
module pmod_sync_edge
    import pmod_pkg::*;
(
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESET,
    input  logic              pck,
    input  logic              pwrite,
    input  logic [BEAT_W-1:0] pwd,
    output logic              beat,
    output logic              pck_edge,
    output logic              pwrite_sync,
    output logic [BEAT_W-1:0] pwd_sync
);

    logic [2:0]        pck_s;
    logic              pwrite_s1;
    logic [BEAT_W-1:0] pwd_s1;

    // NOTE: synchronizer flops are reset so a mid-frame reset cannot leave a stale pck edge behind.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            pck_s       <= '0;
            pwrite_s1   <= 1'b0;
            pwrite_sync <= 1'b0;
            pwd_s1      <= '0;
            pwd_sync    <= '0;
        end else begin
            pck_s       <= {pck_s[1:0], pck};
            pwrite_s1   <= pwrite;
            pwrite_sync <= pwrite_s1;
            pwd_s1      <= pwd;
            pwd_sync    <= pwd_s1;
        end
    end

    // pwd_sync shares the pck_s[1] stage, so it is the mid-beat value at the falling edge.
    assign beat     = pck_s[2] & ~pck_s[1];
    assign pck_edge = pck_s[2] ^ pck_s[1];

endmodule

// File: rtl/pmod_frame_rx.sv
// PMOD frame receiver: deserializes 2-bit beat frames into AXI engine commands
// and serializes read responses back to the host on prd.
module pmod_frame_rx
    import pmod_pkg::*;
#(
    parameter int LEN_BEATS  = 5,
    parameter int ADDR_BEATS = 16,
    parameter int MAX_BEATS  = 32,
    parameter int WPAD_BEATS = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESET,
    input  logic              pck,
    input  logic              pwrite,
    input  logic [BEAT_W-1:0] pwd,
    output logic [BEAT_W-1:0] prd,
    output logic              pwait,
    output logic              frame_err,
    pmod_frame_rx_if.master   axi_cmd
);

    localparam int               TO_W      = $clog2(TIMEOUT) + 1;
    localparam int               IDX_W     = $clog2(MAX_BEATS);
    localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(LEN_BEATS - 1);
    localparam logic [LEN_W-1:0] ADDR_LAST = LEN_W'(ADDR_BEATS - 1);
    localparam logic [LEN_W-1:0] PAD_LAST  = LEN_W'(WPAD_BEATS - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BEATS);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    logic              beat;
    logic              pck_edge;
    logic              pwrite_s;
    logic [BEAT_W-1:0] pwd_s;

    pmod_sync_edge u_sync (
        .M_AXI_ACLK  (M_AXI_ACLK),
        .M_AXI_ARESET(M_AXI_ARESET),
        .pck         (pck),
        .pwrite      (pwrite),
        .pwd         (pwd),
        .beat        (beat),
        .pck_edge    (pck_edge),
        .pwrite_sync (pwrite_s),
        .pwd_sync    (pwd_s)
    );

    state_t            state;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_raw;
    logic              is_write;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] rd_shift;
    cmd_t              cmd_q;
    logic              cmd_valid;
    logic              rsp_ready;

    logic [LEN_W-1:0]  len_next;
    logic [ADDR_W-1:0] addr_next;
    logic [LEN_W-1:0]  beat_inc;
    logic              to_run;
    logic              timeout;

    always_comb begin
        len_next  = {pwd_s, len_raw[LEN_W-1:BEAT_W]};
        addr_next = {pwd_s, cmd_q.addr[ADDR_W-1:BEAT_W]};
        beat_inc  = beat_cnt + 1'b1;
        to_run    = !(state == HDR_LEN && beat_cnt == '0);
        timeout   = to_run && state != ISSUE && state != RWAIT && !pck_edge && to_cnt == TO_LAST;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state     <= HDR_LEN;
            beat_cnt  <= '0;
            len_raw   <= '0;
            is_write  <= 1'b0;
            to_cnt    <= '0;
            rd_shift  <= '0;
            cmd_q     <= '0;
            cmd_valid <= 1'b0;
            rsp_ready <= 1'b0;
            prd       <= '0;
            pwait     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // NOTE: later non-blocking writes in this block win, so the RWAIT capture can clear to_cnt.
            if (pck_edge || !to_run) to_cnt <= '0;
            else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

            if (timeout) begin
                state     <= HDR_LEN;
                beat_cnt  <= '0;
                prd       <= '0;
                frame_err <= 1'b1;
            end else begin
                unique case (state)
                    HDR_LEN: if (beat) begin
                        if (beat_cnt == '0) is_write <= pwrite_s;
                        len_raw <= len_next;
                        if (beat_cnt == LEN_LAST) begin
                            state    <= HDR_ADDR;
                            beat_cnt <= '0;
                            if (len_next > MAX_LEN) frame_err <= 1'b1;
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                    HDR_ADDR: if (beat) begin
                        cmd_q.addr <= addr_next;
                        if (beat_cnt == ADDR_LAST) begin
                            beat_cnt    <= '0;
                            cmd_q.write <= is_write;
                            cmd_q.len   <= clamp_len(len_raw, MAX_LEN);
                            if (len_raw == '0) begin
                                state <= HDR_LEN;
                            end else if (is_write) begin
                                state       <= WDATA;
                                cmd_q.wdata <= '0;
                            end else begin
                                state     <= ISSUE;
                                cmd_valid <= 1'b1;
                                pwait     <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                    WDATA: if (beat) begin
                        // Beats past the clamp still count against the full 10-bit length.
                        if (beat_cnt < MAX_LEN)
                            cmd_q.wdata[{beat_cnt[IDX_W-1:0], 1'b0} +: BEAT_W] <= pwd_s;
                        if (beat_inc == len_raw) begin
                            state    <= WPAD;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                    WPAD: if (beat) begin
                        if (beat_cnt == PAD_LAST) begin
                            state     <= ISSUE;
                            beat_cnt  <= '0;
                            cmd_valid <= 1'b1;
                            pwait     <= 1'b1;
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                    ISSUE: if (axi_cmd.cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (cmd_q.write) begin
                            state <= HDR_LEN;
                            pwait <= 1'b0;
                        end else begin
                            state     <= RWAIT;
                            rsp_ready <= 1'b1;
                        end
                    end
                    RWAIT: if (axi_cmd.rsp_valid) begin
                        rd_shift  <= axi_cmd.rsp_data;
                        prd       <= axi_cmd.rsp_data[BEAT_W-1:0];
                        rsp_ready <= 1'b0;
                        pwait     <= 1'b0;
                        to_cnt    <= '0;
                        beat_cnt  <= '0;
                        state     <= RDATA;
                    end
                    RDATA: if (beat) begin
                        if (beat_inc == LEN_W'(cmd_q.len)) begin
                            state    <= HDR_LEN;
                            beat_cnt <= '0;
                            prd      <= '0;
                        end else begin
                            beat_cnt <= beat_inc;
                            rd_shift <= rd_shift >> BEAT_W;
                            prd      <= rd_shift[2*BEAT_W-1:BEAT_W];
                        end
                    end
                    default: state <= HDR_LEN;
                endcase
            end
        end
    end

    assign axi_cmd.cmd_valid = cmd_valid;
    assign axi_cmd.cmd_write = cmd_q.write;
    assign axi_cmd.cmd_len   = cmd_q.len;
    assign axi_cmd.cmd_addr  = cmd_q.addr;
    assign axi_cmd.cmd_wdata = cmd_q.wdata;
    assign axi_cmd.rsp_ready = rsp_ready;

endmodule

// File: tb/tb_pmod_frame_rx.sv
// Self-checking bench for pmod_frame_rx: a host model drives PMOD frames, the bench
// plays the AXI engine, and expectations come from the frame rules directly.
module tb_pmod_frame_rx;
    import pmod_pkg::*;

    localparam int MAX_BEATS  = 32;
    localparam int WPAD_BEATS = 12;
    localparam int TIMEOUT    = 1024;

    logic       aclk = 1'b0;
    logic       areset;
    logic       pck;
    logic       pwrite;
    logic [1:0] pwd;
    logic [1:0] prd;
    logic       pwait;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_ferr = 0;

    pmod_frame_rx_if bus ();

    pmod_frame_rx #(
        .LEN_BEATS (5),
        .ADDR_BEATS(16),
        .MAX_BEATS (MAX_BEATS),
        .WPAD_BEATS(WPAD_BEATS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .M_AXI_ACLK  (aclk),
        .M_AXI_ARESET(areset),
        .pck         (pck),
        .pwrite      (pwrite),
        .pwd         (pwd),
        .prd         (prd),
        .pwait       (pwait),
        .frame_err   (frame_err),
        .axi_cmd     (bus)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (bus.cmd_valid && bus.cmd_ready) n_acc++;
        if (frame_err) n_ferr++;
    end

    // Host beat: pwd changes just after the rise, device samples it at the fall.
    task automatic drive_beat(input logic [1:0] v);
        pck = 1'b1; #2; pwd = v; #25; pck = 1'b0; #28;
    endtask

    task automatic rd_beat(output logic [1:0] seen);
        pck = 1'b1; #2; pwd = 2'($urandom); #25; seen = prd; pck = 1'b0; #28;
    endtask

    task automatic send_header(input bit w, input int len, input logic [31:0] addr);
        logic [9:0] l;
        l = 10'(len);
        pwrite = w;
        for (int k = 0; k < 5; k++) drive_beat(l[2*k +: 2]);
        for (int k = 0; k < 16; k++) drive_beat(addr[2*k +: 2]);
    endtask

    task automatic run_frame(input bit w, input int len, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [63:0] rd,
                             input int rdy_dly, input string tag);
        int         eff, ferr0, acc0;
        logic [63:0] exp_wd;
        logic [1:0]  seen;
        bit          ok;
        eff   = (len > MAX_BEATS) ? MAX_BEATS : len;
        ferr0 = n_ferr;
        acc0  = n_acc;
        exp_wd = '0;
        for (int k = 0; k < eff; k++) exp_wd[2*k +: 2] = wd[2*k +: 2];

        send_header(w, len, addr);
        if (w && len > 0) begin
            for (int k = 0; k < len; k++) drive_beat(k < MAX_BEATS ? wd[2*k +: 2] : 2'($urandom));
            for (int k = 0; k < WPAD_BEATS; k++) drive_beat(2'($urandom));
        end

        if (len == 0) begin
            repeat (30) @(negedge aclk);
            checks++;
            if (n_acc !== acc0 || bus.cmd_valid !== 1'b0 || pwait !== 1'b0) begin
                errors++;
                $display("FAIL %s zero_len: accepts=%0d valid=%b pwait=%b, expected 0 0 0",
                         tag, n_acc - acc0, bus.cmd_valid, pwait);
            end
        end else begin
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge aclk);
                if (bus.cmd_valid) ok = 1'b1;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s cmd_valid: got 0, expected 1 within 200 cycles", tag);
            end
            checks++;
            if (bus.cmd_write !== w || bus.cmd_len !== 6'(eff) || bus.cmd_addr !== addr || pwait !== 1'b1) begin
                errors++;
                $display("FAIL %s cmd_fields: write=%b len=%0d addr=%h pwait=%b, expected %b %0d %h 1",
                         tag, bus.cmd_write, bus.cmd_len, bus.cmd_addr, pwait, w, eff, addr);
            end
            if (w) begin
                checks++;
                if (bus.cmd_wdata !== exp_wd) begin
                    errors++;
                    $display("FAIL %s cmd_wdata: got %h, expected %h", tag, bus.cmd_wdata, exp_wd);
                end
            end
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge aclk);
                checks++;
                if (bus.cmd_valid !== 1'b1 || bus.cmd_write !== w || bus.cmd_len !== 6'(eff) ||
                    bus.cmd_addr !== addr || pwait !== 1'b1 || (w && bus.cmd_wdata !== exp_wd)) begin
                    errors++;
                    $display("FAIL %s hold_%0d: valid=%b len=%0d addr=%h wdata=%h pwait=%b, expected 1 %0d %h %h 1",
                             tag, i, bus.cmd_valid, bus.cmd_len, bus.cmd_addr, bus.cmd_wdata, pwait,
                             eff, addr, exp_wd);
                end
            end
            bus.cmd_ready = 1'b1;
            @(negedge aclk);
            bus.cmd_ready = 1'b0;
            checks++;
            if (n_acc !== acc0 + 1 || bus.cmd_valid !== 1'b0 || pwait !== !w) begin
                errors++;
                $display("FAIL %s accept: accepts=%0d valid=%b pwait=%b, expected 1 0 %b",
                         tag, n_acc - acc0, bus.cmd_valid, pwait, !w);
            end
            if (!w) begin
                repeat (2) @(negedge aclk);
                checks++;
                if (bus.rsp_ready !== 1'b1 || pwait !== 1'b1 || prd !== 2'b00) begin
                    errors++;
                    $display("FAIL %s rwait: rsp_ready=%b pwait=%b prd=%b, expected 1 1 00",
                             tag, bus.rsp_ready, pwait, prd);
                end
                bus.rsp_data  = rd;
                bus.rsp_valid = 1'b1;
                @(negedge aclk);
                bus.rsp_valid = 1'b0;
                checks++;
                if (pwait !== 1'b0 || bus.rsp_ready !== 1'b0 || prd !== rd[1:0]) begin
                    errors++;
                    $display("FAIL %s capture: pwait=%b rsp_ready=%b prd=%b, expected 0 0 %b",
                             tag, pwait, bus.rsp_ready, prd, rd[1:0]);
                end
                for (int k = 0; k < eff; k++) begin
                    rd_beat(seen);
                    checks++;
                    if (seen !== rd[2*k +: 2]) begin
                        errors++;
                        $display("FAIL %s prd_beat_%0d: got %b, expected %b", tag, k, seen, rd[2*k +: 2]);
                    end
                end
                repeat (3) @(negedge aclk);
                checks++;
                if (prd !== 2'b00 || pwait !== 1'b0) begin
                    errors++;
                    $display("FAIL %s after_rdata: prd=%b pwait=%b, expected 00 0", tag, prd, pwait);
                end
            end
            repeat (5) @(negedge aclk);
            checks++;
            if (n_acc !== acc0 + 1) begin
                errors++;
                $display("FAIL %s single_cmd: got %0d accepts, expected 1", tag, n_acc - acc0);
            end
        end
        checks++;
        if (n_ferr - ferr0 !== ((len > MAX_BEATS) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s frame_err: got %0d pulses, expected %0d",
                     tag, n_ferr - ferr0, (len > MAX_BEATS) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if (prd !== 2'b00 || pwait !== 1'b0 || bus.cmd_valid !== 1'b0 || bus.rsp_ready !== 1'b0 ||
            frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: prd=%b pwait=%b valid=%b rsp_ready=%b err=%b, expected all 0",
                     prd, pwait, bus.cmd_valid, bus.rsp_ready, frame_err);
        end
        checks++;
        if (bus.cmd_write !== 1'b0 || bus.cmd_len !== 6'd0 || bus.cmd_addr !== 32'd0 || bus.cmd_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_fields: write=%b len=%0d addr=%h wdata=%h, expected all 0",
                     bus.cmd_write, bus.cmd_len, bus.cmd_addr, bus.cmd_wdata);
        end
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_read();
        run_frame(1'b0, 4, 32'h4000_0000, 64'd0, 64'hdead_beef, 0, "read");
    endtask

    task automatic test_write();
        run_frame(1'b1, 4, 32'h4060_0004, 64'h68, 64'd0, 0, "write");
        run_frame(1'b0, 3, $urandom, 64'd0, {$urandom, $urandom}, 1, "write_next");
    endtask

    task automatic test_backpressure();
        run_frame(1'b1, 9, $urandom, {$urandom, $urandom}, 64'd0, 20, "bp_write");
        run_frame(1'b0, 5, $urandom, 64'd0, {$urandom, $urandom}, 20, "bp_read");
    endtask

    task automatic test_timeout();
        int  ferr0, wait_cyc;
        bit  seen_err;
        ferr0 = n_ferr;
        pwrite = 1'b0;
        for (int k = 0; k < 5; k++) drive_beat(k == 1 ? 2'b01 : 2'b00);
        drive_beat(2'b10);
        drive_beat(2'b11);
        seen_err = 1'b0;
        wait_cyc = 0;
        for (int i = 0; i < TIMEOUT + 200 && !seen_err; i++) begin
            @(negedge aclk);
            wait_cyc++;
            if (frame_err) seen_err = 1'b1;
        end
        checks++;
        if (!seen_err || wait_cyc < TIMEOUT - 5 || wait_cyc > TIMEOUT + 10) begin
            errors++;
            $display("FAIL timeout_delay: pulse=%b after %0d cycles, expected 1 after about %0d",
                     seen_err, wait_cyc, TIMEOUT);
        end
        repeat (50) @(negedge aclk);
        checks++;
        if (n_ferr - ferr0 !== 1 || bus.cmd_valid !== 1'b0 || pwait !== 1'b0) begin
            errors++;
            $display("FAIL timeout_once: pulses=%0d valid=%b pwait=%b, expected 1 0 0",
                     n_ferr - ferr0, bus.cmd_valid, pwait);
        end
        run_frame(1'b0, 6, $urandom, 64'd0, {$urandom, $urandom}, 0, "after_timeout");
    endtask

    task automatic test_clamp();
        run_frame(1'b0, 40, $urandom, 64'd0, {$urandom, $urandom}, 0, "clamp_read");
        run_frame(1'b1, 37, $urandom, {$urandom, $urandom}, 64'd0, 2, "clamp_write");
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic [1:0]  seen;
        bit          ok;
        rd = {$urandom, $urandom} | 64'h30;
        send_header(1'b0, 4, 32'h1234_5678);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            if (bus.cmd_valid) ok = 1'b1;
        end
        bus.cmd_ready = 1'b1;
        @(negedge aclk);
        bus.cmd_ready = 1'b0;
        repeat (2) @(negedge aclk);
        bus.rsp_data  = rd;
        bus.rsp_valid = 1'b1;
        @(negedge aclk);
        bus.rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_beat(seen);
            checks++;
            if (seen !== rd[2*k +: 2]) begin
                errors++;
                $display("FAIL mid_prd_%0d: got %b, expected %b", k, seen, rd[2*k +: 2]);
            end
        end
        repeat (2) @(negedge aclk);
        checks++;
        if (!ok || prd !== rd[5:4]) begin
            errors++;
            $display("FAIL mid_beat2: cmd=%b prd=%b, expected 1 %b", ok, prd, rd[5:4]);
        end
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if (prd !== 2'b00 || pwait !== 1'b0 || bus.rsp_ready !== 1'b0 || bus.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: prd=%b pwait=%b rsp_ready=%b valid=%b, expected 00 0 0 0",
                     prd, pwait, bus.rsp_ready, bus.cmd_valid);
        end
        areset = 1'b0;
        @(negedge aclk);
        run_frame(1'b0, 4, $urandom, 64'd0, {$urandom, $urandom}, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom,
                      {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 5), "random");
        end
    endtask

    initial begin
        areset        = 1'b1;
        pck           = 1'b0;
        pwrite        = 1'b0;
        pwd           = 2'b00;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_timeout();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
